knn_sorter: RTL
===============

Name: knn_sorter

Overview:
- Downstream stage of the distance calculator in the KNN accelerator.
- Accepts one (distance, label) pair per handshake and keeps a running list of the K smallest distances, sorted ascending, with their labels.
- When the last training point is flagged, it freezes the list and signals done.
- The voting logic and the CPU read the frozen list through a registered read port.

Parameters:
- W, 32, distance width (unsigned, matches distance calculator output).
- LABEL_W, 8, class label width.
- K, 10, number of neighbours kept (2..32).
- AW, 5, read address width, with 2**AW >= K.

Ports:
- clk  input  1  clock
- rst  input  1  asynchronous reset, active-low
- clr  input  1  synchronous clear: empty list, return to IDLE
- valid_in  input  1  distance/label pair valid
- ready_out  output  1  block accepts pair this cycle
- last_in  input  1  qualifies valid_in: this pair is the final training point
- dist_in  input  W  distance from distance calculator
- label_in  input  LABEL_W  label of the training point
- done  output  1  list frozen and valid
- count  output  AW+1  number of occupied entries (0..K)
- rd_addr  input  AW  read index, 0 = nearest
- rd_dist  output  W  distance at rd_addr, registered
- rd_label  output  LABEL_W  label at rd_addr, registered

Behaviour:
- Reset (rst low, asynchronous) takes effect immediately, including mid-operation:
  - all entries dist = all-ones, label = 0
  - count = 0, done = 0, rd_dist = all-ones, rd_label = 0
  - state = IDLE, ready_out = 0 while rst is low
- FSM states IDLE, COLLECT, DONE:
  - IDLE: ready_out = 1. An accepted pair moves to COLLECT, or to DONE if last_in = 1.
  - COLLECT: ready_out = 1. An accepted pair with last_in = 1 moves to DONE.
  - DONE: ready_out = 0, done = 1. Only clr (or rst) leaves DONE, back to IDLE.
- Accept = valid_in & ready_out. valid_in while ready_out = 0 is ignored; the producer must hold it.
- Insertion is a parallel compare-and-shift on all K slots, 1 cycle:
  - The list and count update on the clock edge that accepts the pair.
  - The new state is visible on the following cycle. Throughput is 1 pair/cycle, back-to-back.
- Comparison is unsigned. The insert position p is the first slot whose dist > dist_in (strict).
  - Equal distances therefore keep arrival order: the new entry goes after existing equal entries.
  - Slots p..K-2 shift down one place. Slot K-1 is dropped when the list is full.
- Full list (count == K) and dist_in >= slot K-1 dist: the pair is accepted and discarded, and the list is unchanged.
- count increments on each accepted pair and saturates at K.
- dist_in = all-ones while not full: inserted normally and counted. It is indistinguishable from an empty slot in rd_dist; consumers use count.
- last_in on the accepting pair: that pair is inserted first, done rises the next cycle, together with the final list.
- clr has priority over valid_in in the same cycle: the pair is dropped, the list is emptied, and the block is in IDLE the next cycle. clr is legal in any state.
- Read port:
  - rd_dist/rd_label are registered from rd_addr with 1-cycle latency, in any state.
  - rd_addr >= K returns all-ones / 0.
  - Reading during COLLECT returns the current partial list.
- No other outputs change in DONE.

Test Plan:
- Reset, then K=4, feed dists 50,20,80,10 (labels 1,2,3,4), last on the 4th -> done after 1 cycle, count=4, reads 0..3 give 10/4, 20/2, 50/1, 80/3.
- K=4, feed 9 back-to-back pairs (valid held high) with dists 90,70,50,30,10,20,40,60,80, last on 9th -> ready_out high throughout, final list 10,20,30,40, count=4.
- Ties, K=4: dists 5(L1),5(L2),3(L3),5(L4),5(L5) -> list 3/L3, 5/L1, 5/L2, 5/L4. The L5 pair is discarded.
- Full-list discard, K=4: list 1,2,3,4 in COLLECT, then feed 4 and 100 -> list unchanged, count stays 4.
- Assert clr in the same cycle as valid_in = 1 with dist 7 during COLLECT -> next cycle count=0, state IDLE, and reading addr 0 gives all-ones/0. Then valid in DONE with ready_out=0 -> ignored.
- Pulse rst low asynchronously (between edges) during COLLECT with 3 entries -> count=0, done=0, ready_out=0 immediately. After release, ready_out=1 and a new stream sorts correctly.

Source files
------------

// File: rtl/knn_sorter.sv
// Running K-nearest list: keeps the K smallest (distance, label) pairs sorted
// ascending, freezes on the last training point and exposes a registered read port.
module knn_sorter #(
  parameter int W       = 32,
  parameter int LABEL_W = 8,
  parameter int K       = 10,
  parameter int AW      = 5
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               clr,
  input  logic               valid_in,
  output logic               ready_out,
  input  logic               last_in,
  input  logic [W-1:0]       dist_in,
  input  logic [LABEL_W-1:0] label_in,
  output logic               done,
  output logic [AW:0]        count,
  input  logic [AW-1:0]      rd_addr,
  output logic [W-1:0]       rd_dist,
  output logic [LABEL_W-1:0] rd_label
);

  typedef enum logic [1:0] {ST_IDLE, ST_COLLECT, ST_DONE} state_e;

  state_e             state_q, state_d;
  logic [AW:0]        count_q, count_d;
  logic [W-1:0]       dist_q  [K];
  logic [W-1:0]       dist_d  [K];
  logic [LABEL_W-1:0] label_q [K];
  logic [LABEL_W-1:0] label_d [K];
  logic [W-1:0]       rd_dist_q, rd_dist_d;
  logic [LABEL_W-1:0] rd_label_q, rd_label_d;
  logic [K-1:0]       gt;
  logic               accept;

  // Gated by rst so the producer sees a stall for the whole reset pulse.
  assign ready_out = rst & (state_q != ST_DONE);
  assign accept    = valid_in & ready_out;
  assign done      = (state_q == ST_DONE);
  assign count     = count_q;
  assign rd_dist   = rd_dist_q;
  assign rd_label  = rd_label_q;

  // Unoccupied slots always lose the compare, so an all-ones distance is still
  // inserted and counted. gt is monotone: once set it stays set for higher slots.
  always_comb begin
    for (int i = 0; i < K; i++) begin
      gt[i] = ((AW+1)'(i) >= count_q) || (dist_q[i] > dist_in);
    end
  end

  // NOTE: every signal gets a default at the top of an always_comb so that no
  // path leaves it unassigned, which would otherwise infer a latch.
  always_comb begin
    state_d = state_q;
    count_d = count_q;
    dist_d  = dist_q;
    label_d = label_q;
    if (clr) begin
      state_d = ST_IDLE;
      count_d = '0;
      for (int i = 0; i < K; i++) begin
        dist_d[i]  = '1;
        label_d[i] = '0;
      end
    end else if (accept) begin
      if (gt[0]) begin
        dist_d[0]  = dist_in;
        label_d[0] = label_in;
      end
      for (int i = 1; i < K; i++) begin
        if (gt[i]) begin
          dist_d[i]  = gt[i-1] ? dist_q[i-1]  : dist_in;
          label_d[i] = gt[i-1] ? label_q[i-1] : label_in;
        end
      end
      if (count_q != (AW+1)'(K)) count_d = count_q + 1'b1;
      if (last_in)                  state_d = ST_DONE;
      else if (state_q == ST_IDLE)  state_d = ST_COLLECT;
    end
  end

  always_comb begin
    rd_dist_d  = '1;
    rd_label_d = '0;
    for (int i = 0; i < K; i++) begin
      if (rd_addr == AW'(i)) begin
        rd_dist_d  = dist_q[i];
        rd_label_d = label_q[i];
      end
    end
  end

  // NOTE: the list is a small register file, not RAM, so resetting every entry
  // is cheap and guarantees reads of empty slots return all-ones / 0.
  // NOTE: sequential state uses non-blocking assignments only, so every flop
  // samples the pre-edge value of its _d regardless of statement order.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= ST_IDLE;
      count_q    <= '0;
      rd_dist_q  <= '1;
      rd_label_q <= '0;
      for (int i = 0; i < K; i++) begin
        dist_q[i]  <= '1;
        label_q[i] <= '0;
      end
    end else begin
      state_q    <= state_d;
      count_q    <= count_d;
      rd_dist_q  <= rd_dist_d;
      rd_label_q <= rd_label_d;
      dist_q     <= dist_d;
      label_q    <= label_d;
    end
  end

endmodule
